// File: rtl/sm_div_pkg.sv
// Shared types and helpers for the sign-magnitude restoring divider.
package sm_div_pkg;

    // Default operand width (divisor/quotient/remainder; dividend is twice this)
    localparam int DEF_W = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns the sign to emit for a magnitude: a zero magnitude never carries a sign,
    // so -0 can never leave the block. The magnitude is zero-extended by the caller.
    function automatic logic sm_fix_sign(input logic [63:0] mag, input logic sign);
        return (mag == 64'd0) ? 1'b0 : sign;
    endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division iteration: shift the quotient MSB into the partial
// remainder, then subtract the divisor magnitude if it fits.
module sm_div_step #(
    parameter int W = 8
) (
    input  logic [W-2:0] r,
    input  logic [W-2:0] q,
    input  logic [W-2:0] dm,
    output logic [W-2:0] r_nxt,
    output logic [W-2:0] q_nxt
);

    logic [W-1:0] s;
    logic         ge;

    // Trial subtract. Since r < dm on entry, s < 2*dm, so s - dm always fits in
    // W-1 bits and the low-bit subtraction below is exact.
    always_comb begin
        s     = {r, q[W-2]};
        ge    = (s >= {1'b0, dm});
        r_nxt = ge ? (s[W-2:0] - dm) : s[W-2:0];
        q_nxt = {q[W-3:0], ge};
    end

endmodule

// File: rtl/sm_divider.sv
// Sequential restoring divider for sign-magnitude operands: 2W-bit dividend by
// W-bit divisor, giving a W-bit quotient and remainder (truncating division).
module sm_divider
    import sm_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);

    state_t         state;
    logic [2*W-1:0] dvd_q;
    logic [W-1:0]   dvs_q;
    logic [W-2:0]   r_q;
    logic [W-2:0]   q_q;
    logic [CW-1:0]  cnt;

    logic [W-2:0]   dm;
    logic [W-1:0]   hm;
    logic [W-2:0]   r_nxt;
    logic [W-2:0]   q_nxt;
    logic           q_sign;
    logic           r_sign;

    // Latched-operand views and sign of the result being produced this step
    always_comb begin
        dm     = dvs_q[W-2:0];
        hm     = dvd_q[2*W-2:W-1];
        q_sign = sm_fix_sign(64'(q_nxt), dvd_q[2*W-1] ^ dvs_q[W-1]);
        r_sign = sm_fix_sign(64'(r_nxt), dvd_q[2*W-1]);
    end

    sm_div_step #(.W(W)) u_step (
        .r     (r_q),
        .q     (q_q),
        .dm    (dm),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    // Controller: latch, pre-check, W-1 iterations, one-cycle done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (dm == '0) begin
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                        quotient  <= '0;
                        remainder <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (hm >= {1'b0, dm}) begin
                        // Upper half already >= divisor: quotient needs W or more bits
                        div_zero  <= 1'b0;
                        overflow  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        r_q   <= hm[W-2:0];
                        q_q   <= dvd_q[W-2:0];
                        cnt   <= CW'(W-1);
                        state <= ITER;
                    end
                end
                ITER: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient  <= {q_sign, q_nxt};
                        remainder <= {r_sign, r_nxt};
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_divider.sv
// Directed bench for sm_divider (W=8): arithmetic, error flags, latency and control.
module tb_sm_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    sm_divider #(.W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the operand inputs after the start edge,
    // then check latency, busy coverage and the results on the done pulse.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input int elat);
        int   k;
        logic bz;
        @(negedge clock);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clock);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        k  = 0;
        bz = 1'b1;
        while (!done && k < 40) begin
            bz = bz & busy;
            @(negedge clock);
            k++;
        end
        bz = bz & busy;
        chk({tag, " latency"}, 32'(k), 32'(elat));
        chk({tag, " busy"}, 32'(bz), 32'd1);
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(edz));
        chk({tag, " overflow"}, 32'(overflow), 32'(eov));
        @(negedge clock);
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
        chk({tag, " hold q"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int k;
        int first;
        int second;
        int extra;
        logic bz;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = 16'h0;
        divisor  = 8'h0;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Arithmetic and sign rules
        run_op("p100/7",    16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8);
        run_op("n100/7",    16'h8064, 8'h07, 8'h8E, 8'h82, 1'b0, 1'b0, 8);
        run_op("p1000/n9",  16'h03E8, 8'h89, 8'hEF, 8'h01, 1'b0, 1'b0, 8);
        run_op("div -0",    16'h0005, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1);
        run_op("ovf 1024/8",16'h0400, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        run_op("1023/8",    16'h03FF, 8'h08, 8'h7F, 8'h07, 1'b0, 1'b0, 8);
        run_op("n3/5",      16'h8003, 8'h05, 8'h00, 8'h83, 1'b0, 1'b0, 8);

        // start pulsed mid-ITER is ignored
        @(negedge clock);
        start    = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(negedge clock);
        start    = 1'b0;
        dividend = 16'h0400;
        divisor  = 8'h03;
        k  = 0;
        bz = 1'b1;
        while (!done && k < 40) begin
            bz = bz & busy;
            start = (k == 3);
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        chk("midstart latency", 32'(k), 32'd8);
        chk("midstart busy", 32'(bz), 32'd1);
        chk("midstart quotient", 32'(quotient), 32'h0E);
        chk("midstart remainder", 32'(remainder), 32'h02);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("midstart no rerun", 32'(extra), 32'd0);

        // start held high: back-to-back runs W+2 cycles apart
        @(negedge clock);
        start    = 1'b1;
        dividend = 16'h03E8;
        divisor  = 8'h89;
        k      = 0;
        first  = -1;
        second = -1;
        while (second < 0 && k < 60) begin
            @(negedge clock);
            k++;
            if (done) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        start = 1'b0;
        chk("held first done", 32'(first), 32'd9);
        chk("held spacing", 32'(second - first), 32'd10);
        chk("held quotient", 32'(quotient), 32'hEF);
        repeat (3) @(negedge clock);
        chk("held stops", 32'(busy), 32'd0);

        // Reset mid-ITER aborts without a done pulse
        @(negedge clock);
        start    = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre-abort busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done || busy) extra++;
        end
        chk("abort no done", 32'(extra), 32'd0);

        // Recovery after abort
        run_op("post-abort", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
